clint_timer: RTL

- Memory-mapped core-local interruptor. It owns `mtime`, `mtimecmp` and the machine/supervisor software-interrupt bits.
- It drives `mem_msip`, `mem_ssip`, `mem_mtime` and `mem_mtimecmp` straight into the CSR block, which derives MSIP/SSIP/MTIP in `mip` from them.
- It sits on the data-memory bus as a slave and answers one request at a time with a single-cycle ack.

---
 rtl/clint_timer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/clint_timer.sv
// Core-local interruptor: owns mtime/mtimecmp and the msip/ssip bits, exposed as a
// single-outstanding data-bus slave with a one-cycle ack.
module clint_timer #(
  parameter int unsigned CLOCK_CYCLES = 10,
  parameter int unsigned ADDR_SIZE    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [31:0]          wr_data,
  input  logic [3:0]           byte_en,
  output logic [31:0]          rd_data,
  output logic                 ack,
  output logic                 mem_msip,
  output logic                 mem_ssip,
  output logic [63:0]          mem_mtime,
  output logic [63:0]          mem_mtimecmp
);

  localparam int unsigned PrescW = (CLOCK_CYCLES > 1) ? $clog2(CLOCK_CYCLES) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(CLOCK_CYCLES - 1);

  localparam logic [ADDR_SIZE-1:0] AddrMsip     = ADDR_SIZE'(32'h0000);
  localparam logic [ADDR_SIZE-1:0] AddrSsip     = ADDR_SIZE'(32'h0004);
  localparam logic [ADDR_SIZE-1:0] AddrCmpLo    = ADDR_SIZE'(32'h4000);
  localparam logic [ADDR_SIZE-1:0] AddrCmpHi    = ADDR_SIZE'(32'h4004);
  localparam logic [ADDR_SIZE-1:0] AddrMtimeLo  = ADDR_SIZE'(32'hBFF8);
  localparam logic [ADDR_SIZE-1:0] AddrMtimeHi  = ADDR_SIZE'(32'hBFFC);

  typedef enum logic {StIdle, StAck} state_e;

  state_e              state_q, state_d;
  logic [PrescW-1:0]   presc_q, presc_d;
  logic [63:0]         mtime_q, mtime_d;
  logic [63:0]         mtimecmp_q, mtimecmp_d;
  logic                msip_q, msip_d;
  logic                ssip_q, ssip_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic [ADDR_SIZE-1:0] word_addr;
  logic [31:0]         rd_mux;
  logic                tick;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Byte-offset bits [1:0] are don't-care.
  assign word_addr = addr & ~ADDR_SIZE'(3);
  assign tick      = (presc_q == PrescMax);

  always_comb begin
    rd_mux = 32'h0;
    case (word_addr)
      AddrMsip:    rd_mux = {31'h0, msip_q};
      AddrSsip:    rd_mux = {31'h0, ssip_q};
      AddrCmpLo:   rd_mux = mtimecmp_q[31:0];
      AddrCmpHi:   rd_mux = mtimecmp_q[63:32];
      AddrMtimeLo: rd_mux = mtime_q[31:0];
      AddrMtimeHi: rd_mux = mtime_q[63:32];
      default:     rd_mux = 32'h0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rd_data_d  = rd_data_q;
    msip_d     = msip_q;
    ssip_d     = ssip_q;
    mtimecmp_d = mtimecmp_q;
    presc_d    = tick ? '0 : presc_q + 1'b1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;

    unique case (state_q)
      StIdle: begin
        if (rd_en || wr_en) begin
          state_d = StAck;
          if (rd_en) rd_data_d = rd_mux;
          if (wr_en) begin
            case (word_addr)
              AddrMsip:  if (byte_en[0]) msip_d = wr_data[0];
              AddrSsip:  if (byte_en[0]) ssip_d = wr_data[0];
              AddrCmpLo: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], wr_data, byte_en);
              AddrCmpHi: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wr_data, byte_en);
              // Software write beats a coincident tick and restarts the prescaler.
              AddrMtimeLo: begin
                mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wr_data, byte_en)};
                presc_d = '0;
              end
              AddrMtimeHi: begin
                mtime_d = {merge_bytes(mtime_q[63:32], wr_data, byte_en), mtime_q[31:0]};
                presc_d = '0;
              end
              default: ;
            endcase
          end
        end
      end
      StAck: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      mtime_q    <= 64'h0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q     <= 1'b0;
      ssip_q     <= 1'b0;
      rd_data_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      ssip_q     <= ssip_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign ack          = (state_q == StAck);
  assign rd_data      = rd_data_q;
  assign mem_msip     = msip_q;
  assign mem_ssip     = ssip_q;
  assign mem_mtime    = mtime_q;
  assign mem_mtimecmp = mtimecmp_q;

endmodule
